// File: rtl/riscv_fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package riscv_fetch_pkg;

    localparam int                  FETCH_DW         = 32;
    localparam logic [FETCH_DW-1:0] RESET_PC_DEF     = 32'h0000_0000;
    // Instructions are word aligned; redirect targets have these low bits cleared.
    localparam int                  INSTR_ALIGN_BITS = 2;

    // One prefetch buffer entry as seen by decode.
    typedef struct packed {
        logic [FETCH_DW-1:0] pc;
        logic [FETCH_DW-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush, occupancy count and full/empty flags.
// Latency: a push is visible at head_dat_o the cycle after it is written.
// Backpressure: push while full is honoured only together with a pop; flush drops everything.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_dat_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_dat_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    // Pointers wrap explicitly so depths that are not a power of two also work.
    function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o     = (r_count == CW'(DEPTH));
    assign empty_o    = (r_count == '0);
    assign count_o    = r_count;
    assign head_dat_o = r_mem[r_rd_ptr];

    assign w_pop  = pop_i && !empty_o && !flush_i;
    assign w_push = push_i && !flush_i && (!full_o || w_pop);

    // Storage and pointer update; contents are cleared on reset so the head reads zero.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_dat_i;
                r_wr_ptr        <= f_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_inc(r_rd_ptr);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // A push into a full FIFO without a matching pop would lose data.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_i)
        !(push_i && !flush_i && full_o && !(pop_i && !empty_o)));

endmodule

// File: rtl/riscv_fetch_unit.sv
// Decoupled fetch front end: credit-limited imem requests, in-order prefetch FIFO, valid/ready to decode.
// Latency: with a 1-cycle memory, decode sees an instruction 2 cycles after its request, 3 after a redirect.
// Backpressure: decode stall fills the FIFO, then credits stop new requests; optional FETCH_PERF_CNT_EN adds counters.
module riscv_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter int          DW              = 32,
    parameter int          ADDENT          = 4,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [DW-1:0] RESET_PC      = DW'(RESET_PC_DEF)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    output logic          imem_req_valid_o,
    input  logic          imem_req_ready_i,
    output logic [DW-1:0] imem_req_addr_o,
    input  logic          imem_rsp_valid_i,
    input  logic [DW-1:0] imem_rsp_data_i,
    input  logic          redirect_i,
    input  logic [DW-1:0] redirect_pc_i,
    output logic          instr_valid_o,
    input  logic          instr_ready_i,
    output logic [DW-1:0] instr_o,
    output logic [DW-1:0] pc_o,
    output logic [DW-1:0] pc_plus_4_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]   perf_fetched_o,
    output logic [31:0]   perf_dropped_o
`endif
);

    localparam int OW  = $clog2(MAX_OUTSTANDING+1);
    localparam int FCW = $clog2(FIFO_DEPTH+1);

    logic          r_run;
    logic [DW-1:0] r_fetch_pc;
    logic [OW-1:0] r_outstanding;
    logic [OW-1:0] r_drop_cnt;

    logic [FCW-1:0]  w_fifo_count;
    logic            w_fifo_empty;
    logic            w_fifo_full;
    logic [2*DW-1:0] w_head;
    logic [DW-1:0]   w_rsp_pc;
    logic [OW-1:0]   w_pcq_count;
    logic            w_pcq_full;
    logic            w_pcq_empty;
    logic [31:0]     w_inflight;
    logic            w_credit;
    logic            w_req_fire;
    logic            w_rsp;
    logic            w_drop;
    logic            w_push;
    logic            w_pop;
    logic            w_unused;

    // A response with nothing outstanding is a memory protocol error and is ignored.
    assign w_rsp = imem_rsp_valid_i && (r_outstanding != '0);

    // Every buffered or still-wanted in-flight instruction holds one FIFO slot, so the FIFO cannot overflow.
    assign w_inflight = 32'(w_fifo_count) + 32'(r_outstanding) - 32'(r_drop_cnt);
    assign w_credit   = (w_inflight < 32'(FIFO_DEPTH));

    // r_run holds requests off until the first edge after reset release.
    assign imem_req_valid_o = r_run && !redirect_i
                              && (r_outstanding < OW'(MAX_OUTSTANDING)) && w_credit;
    assign imem_req_addr_o  = r_fetch_pc;
    assign w_req_fire       = imem_req_valid_o && imem_req_ready_i;

    assign w_drop = w_rsp && (r_drop_cnt != '0);
    assign w_push = w_rsp && !w_drop && !redirect_i;
    assign w_pop  = instr_valid_o && instr_ready_i && !redirect_i;

    assign instr_valid_o = !w_fifo_empty;
    assign pc_o          = w_head[2*DW-1:DW];
    assign instr_o       = w_head[DW-1:0];
    assign pc_plus_4_o   = pc_o + DW'(ADDENT);

    assign w_unused = ^{redirect_pc_i[INSTR_ALIGN_BITS-1:0], w_pcq_count, w_pcq_full,
                        w_pcq_empty, w_fifo_full};

    // PCs of issued requests, popped as their responses return in order.
    fetch_fifo #(
        .WIDTH (DW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_pc_q (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (1'b0),
        .push_i     (w_req_fire),
        .push_dat_i (r_fetch_pc),
        .pop_i      (w_rsp),
        .head_dat_o (w_rsp_pc),
        .count_o    (w_pcq_count),
        .full_o     (w_pcq_full),
        .empty_o    (w_pcq_empty)
    );

    // Prefetch buffer of {pc, instr} presented to decode.
    fetch_fifo #(
        .WIDTH (2*DW),
        .DEPTH (FIFO_DEPTH)
    ) u_instr_q (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (redirect_i),
        .push_i     (w_push),
        .push_dat_i ({w_rsp_pc, imem_rsp_data_i}),
        .pop_i      (w_pop),
        .head_dat_o (w_head),
        .count_o    (w_fifo_count),
        .full_o     (w_fifo_full),
        .empty_o    (w_fifo_empty)
    );

    // Fetch PC, outstanding count and drop count; a redirect marks every in-flight response stale.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_run         <= 1'b0;
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_run         <= 1'b1;
            r_outstanding <= r_outstanding + OW'(w_req_fire) - OW'(w_rsp);
            if (redirect_i) begin
                r_fetch_pc <= {redirect_pc_i[DW-1:INSTR_ALIGN_BITS], {INSTR_ALIGN_BITS{1'b0}}};
                r_drop_cnt <= r_outstanding - OW'(w_rsp);
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + DW'(ADDENT);
                end
                if (w_drop) begin
                    r_drop_cnt <= r_drop_cnt - 1'b1;
                end
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_dropped;

    // Saturating counts of instructions delivered and responses discarded by a redirect.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_perf_fetched <= '0;
            r_perf_dropped <= '0;
        end else begin
            if (w_pop && (r_perf_fetched != '1)) begin
                r_perf_fetched <= r_perf_fetched + 1'b1;
            end
            if ((w_drop || (w_rsp && redirect_i)) && (r_perf_dropped != '1)) begin
                r_perf_dropped <= r_perf_dropped + 1'b1;
            end
        end
    end

    assign perf_fetched_o = r_perf_fetched;
    assign perf_dropped_o = r_perf_dropped;
`endif

    // Memory must never answer a request that was not issued.
    a_rsp_has_req: assert property (@(posedge clk_i) disable iff (!rst_i)
        !(imem_rsp_valid_i && (r_outstanding == '0)));

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Bench for riscv_fetch_unit: in-order memory model with random latency and an expected-stream model.
// The model only tracks the next expected request address and the next expected decode PC.
// Directed scenarios pin timing and boundary values, then a long randomized run follows.
module tb_riscv_fetch_unit;
    import riscv_fetch_pkg::*;

    localparam int          DW          = 32;
    localparam int          FIFO_DEPTH  = 4;
    localparam int          MAX_OUT     = 2;
    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i = 1'b0;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i = 1'b0;
    logic [31:0] imem_rsp_data_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus_4_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_o;
    logic [31:0] perf_dropped_o;
`endif

    always #5 clk_i = ~clk_i;

    riscv_fetch_unit #(
        .DW              (DW),
        .ADDENT          (4),
        .FIFO_DEPTH      (FIFO_DEPTH),
        .MAX_OUTSTANDING (MAX_OUT),
        .RESET_PC        (TB_RESET_PC)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .instr_valid_o    (instr_valid_o),
        .instr_ready_i    (instr_ready_i),
        .instr_o          (instr_o),
        .pc_o             (pc_o),
        .pc_plus_4_o      (pc_plus_4_o)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched_o   (perf_fetched_o),
        .perf_dropped_o   (perf_dropped_o)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Stimulus knobs
    bit          k_rst_n    = 1'b0;
    int          k_lat_min  = 1;
    int          k_lat_max  = 1;
    int          k_ready_pct = 100;
    int          k_dec_pct  = 100;
    int          k_redir_pm = 0;
    bit          k_redir    = 1'b0;
    logic [31:0] k_redir_pc = '0;
    logic [31:0] k_xor      = '0;

    // Model state
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t       mem_q[$];
    logic [31:0] hs_log[$];
    logic [31:0] exp_req = TB_RESET_PC;
    logic [31:0] exp_pc  = TB_RESET_PC;
    int          cyc       = 0;
    int          last_due  = 0;
    int          delivered = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ k_xor;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive inputs at the falling edge, sample after settling, advance the model.
    task automatic step();
        logic        pop;
        logic        fire;
        logic [31:0] tgt;
        int          lat;
        int          due;
        fetch_entry_t e;
        @(negedge clk_i);
        cyc++;
        rst_i            = k_rst_n;
        instr_ready_i    = ($urandom_range(99) < k_dec_pct);
        imem_req_ready_i = ($urandom_range(99) < k_ready_pct);
        redirect_i       = 1'b0;
        redirect_pc_i    = $urandom;
        if (k_redir) begin
            redirect_i    = 1'b1;
            redirect_pc_i = k_redir_pc;
            k_redir       = 1'b0;
        end else if ($urandom_range(999) < k_redir_pm) begin
            redirect_i = 1'b1;
        end
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = $urandom;
        if (k_rst_n && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end
        #1;
        if (!k_rst_n) begin
            exp_req  = TB_RESET_PC;
            exp_pc   = TB_RESET_PC;
            last_due = 0;
            mem_q.delete();
        end else begin
            pop  = instr_valid_o && instr_ready_i && !redirect_i;
            fire = imem_req_valid_o && imem_req_ready_i;
            if (redirect_i) check("no_req_on_redirect", imem_req_valid_o, 0);
            if (instr_valid_o) begin
                e.pc    = exp_pc;
                e.instr = mem_word(exp_pc);
                check("head_pc", pc_o, e.pc);
                check("head_instr", instr_o, e.instr);
                check("head_pc_plus_4", pc_plus_4_o, e.pc + 32'd4);
            end
            if (pop) begin
                delivered++;
                exp_pc = exp_pc + 32'd4;
            end
            if (fire) begin
                check("req_addr", imem_req_addr_o, exp_req);
                hs_log.push_back(imem_req_addr_o);
                lat = int'($urandom_range(k_lat_max, k_lat_min));
                due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                mem_q.push_back('{addr: exp_req, due: due});
                last_due = due;
                exp_req  = exp_req + 32'd4;
                check("fifo_credit", ((exp_req - exp_pc) >> 2) <= FIFO_DEPTH, 1);
                check("max_outstanding", mem_q.size() <= MAX_OUT, 1);
            end
            if (redirect_i) begin
                tgt     = {redirect_pc_i[31:2], 2'b00};
                exp_req = tgt;
                exp_pc  = tgt;
            end
        end
    endtask

    task automatic wait_valid(input string name, input int max_cyc);
        int n = 0;
        while (!instr_valid_o && n < max_cyc) begin
            step();
            n++;
        end
        check(name, instr_valid_o, 1);
    endtask

    task automatic wait_outstanding(input string name, input int want, input int max_cyc);
        int n = 0;
        while (mem_q.size() != want && n < max_cyc) begin
            step();
            n++;
        end
        check(name, mem_q.size(), want);
    endtask

    initial begin
        int d0;
        repeat (3) step();

        // Reset release and first-instruction timing with a 1-cycle memory.
        k_rst_n = 1'b1;
        step();
        check("rst_req_valid", imem_req_valid_o, 0);
        check("rst_instr_valid", instr_valid_o, 0);
        check("rst_instr", instr_o, 32'h0);
        check("rst_pc", pc_o, 32'h0);
        check("rst_pc_plus_4", pc_plus_4_o, 32'h4);
        step();
        check("first_req_valid", imem_req_valid_o, 1);
        check("first_req_addr", imem_req_addr_o, 32'h0);
        step();
        check("first_valid_early", instr_valid_o, 0);
        step();
        check("first_valid", instr_valid_o, 1);
        check("first_pc", pc_o, 32'h0);
        step();
        check("second_pc", pc_o, 32'h4);
        for (int i = 0; i < 12; i++) begin
            step();
            check("steady_rate", instr_valid_o, 1);
        end

        // Decode stall: FIFO fills, credits run out, then the stream resumes intact.
        k_dec_pct = 0;
        repeat (10) step();
        check("stall_valid", instr_valid_o, 1);
        check("stall_req_off", imem_req_valid_o, 0);
        check("stall_buffered", (exp_req - exp_pc) >> 2, 32'd4);
        check("stall_no_inflight", mem_q.size(), 0);
        k_dec_pct = 100;
        repeat (8) step();

        // Redirect with two requests in flight; both responses must be discarded.
        k_lat_min = 3;
        k_lat_max = 3;
        wait_outstanding("redir_setup", 2, 20);
        k_redir    = 1'b1;
        k_redir_pc = 32'h0000_0103;
        step();
        step();
        wait_valid("redir_wait", 20);
        check("redir_first_pc", pc_o, 32'h0000_0100);
`ifdef FETCH_PERF_CNT_EN
        check("perf_dropped", perf_dropped_o, 32'd2);
`endif
        repeat (6) step();

        // Redirect coinciding with a response, memory ready: exact 3-cycle refill.
        k_lat_min = 1;
        k_lat_max = 1;
        repeat (6) step();
        k_redir    = 1'b1;
        k_redir_pc = 32'h0000_0200;
        step();
        step();
        check("redir2_d1", instr_valid_o, 0);
        step();
        check("redir2_d2", instr_valid_o, 0);
        step();
        check("redir2_d3", instr_valid_o, 1);
        check("redir2_first_pc", pc_o, 32'h0000_0200);

        // Fetch address wraps past the top of the address space.
        hs_log.delete();
        k_redir    = 1'b1;
        k_redir_pc = 32'hFFFF_FFF8;
        step();
        repeat (6) step();
        check("wrap_hs_count", hs_log.size() >= 3, 1);
        if (hs_log.size() >= 3) begin
            check("wrap_addr0", hs_log[0], 32'hFFFF_FFF8);
            check("wrap_addr1", hs_log[1], 32'hFFFF_FFFC);
            check("wrap_addr2", hs_log[2], 32'h0000_0000);
        end
        repeat (4) step();

        // Reset in the middle of the stream with two requests outstanding.
        k_lat_min = 3;
        k_lat_max = 3;
        wait_outstanding("mid_rst_setup", 2, 20);
        k_rst_n = 1'b0;
        k_xor   = 32'hC0DE_F00D;
        step();
        k_rst_n = 1'b1;
        step();
        check("mid_rst_req_valid", imem_req_valid_o, 0);
        check("mid_rst_instr_valid", instr_valid_o, 0);
        check("mid_rst_instr", instr_o, 32'h0);
        check("mid_rst_pc", pc_o, 32'h0);
        check("mid_rst_pc_plus_4", pc_plus_4_o, 32'h4);
        step();
        check("mid_rst_restart_valid", imem_req_valid_o, 1);
        check("mid_rst_restart_addr", imem_req_addr_o, TB_RESET_PC);

        // Randomized traffic with occasional redirects and resets.
        k_lat_min   = 1;
        k_lat_max   = 4;
        k_ready_pct = 70;
        k_dec_pct   = 70;
        k_redir_pm  = 25;
        for (int i = 0; i < 3000; i++) begin
            k_rst_n = ($urandom_range(799) != 0);
            step();
        end
        k_rst_n = 1'b1;

        // Drain: with everything ready, the front end must deliver one per cycle again.
        k_lat_min   = 1;
        k_lat_max   = 1;
        k_ready_pct = 100;
        k_dec_pct   = 100;
        k_redir_pm  = 0;
        repeat (10) step();
        d0 = delivered;
        repeat (20) step();
        check("drain_progress", (delivered - d0) >= 15, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
